// File: rtl/ttl373_bus_arbiter.sv
// Round-robin sequencer for a bank of 74LS373-style latches sharing one 8-bit bus: LE pulse, OE_n settle, bus_valid, dead-time release.
// Optional VALID-state watchdog is enabled by defining TTL373_ARB_TIMEOUT_EN.
module ttl373_bus_arbiter #(
    parameter int NUM_SOURCES       = 4,
    parameter int LATCH_CYCLES      = 2,
    parameter int SETTLE_CYCLES     = 2,
    parameter int TURNAROUND_CYCLES = 1,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_SOURCES-1:0] req,
    input  logic                   consumer_ready,
    output logic [NUM_SOURCES-1:0] le,
    output logic [NUM_SOURCES-1:0] oe_n,
    output logic [NUM_SOURCES-1:0] grant,
    output logic                   bus_valid,
    output logic [NUM_SOURCES-1:0] ack,
    output logic                   timeout
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LATCH   = 3'd1;
    localparam logic [2:0] S_DRIVE   = 3'd2;
    localparam logic [2:0] S_VALID   = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam int PW    = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int MAX_A = (LATCH_CYCLES > SETTLE_CYCLES) ? LATCH_CYCLES : SETTLE_CYCLES;
    localparam int MAX_B = (TURNAROUND_CYCLES > TIMEOUT_CYCLES) ? TURNAROUND_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] LATCH_LAST  = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TURN_LAST   = CW'(TURNAROUND_CYCLES - 1);
`ifdef TTL373_ARB_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;
    logic          found;
    logic [PW-1:0] rr_next;

    function automatic logic [NUM_SOURCES-1:0] onehot(input logic [PW-1:0] i);
        return {{(NUM_SOURCES-1){1'b0}}, 1'b1} << i;
    endfunction

    // First requester at or above the rr pointer, wrapping past the top index.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            idx = PW'((int'(rr_ptr) + i) % NUM_SOURCES);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign rr_next = (win == PW'(NUM_SOURCES - 1)) ? '0 : win + PW'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            win       <= '0;
            le        <= '0;
            oe_n      <= '1;
            grant     <= '0;
            bus_valid <= 1'b0;
            ack       <= '0;
`ifdef TTL373_ARB_TIMEOUT_EN
            timeout   <= 1'b0;
`endif
        end else begin
            ack <= '0;
`ifdef TTL373_ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (found) begin
                        win   <= pick;
                        grant <= onehot(pick);
                        le    <= onehot(pick);
                        cnt   <= '0;
                        state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    // LE falls on the same edge OE_n falls, so the latch has already captured D.
                    if (cnt == LATCH_LAST) begin
                        le    <= '0;
                        oe_n  <= ~onehot(win);
                        cnt   <= '0;
                        state <= S_DRIVE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DRIVE: begin
                    if (cnt == SETTLE_LAST) begin
                        bus_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= S_VALID;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_VALID: begin
                    if (consumer_ready) begin
                        oe_n      <= '1;
                        bus_valid <= 1'b0;
                        grant     <= '0;
                        ack       <= onehot(win);
                        rr_ptr    <= rr_next;
                        cnt       <= '0;
                        state     <= S_RELEASE;
                    end
`ifdef TTL373_ARB_TIMEOUT_EN
                    else if (cnt == TIMEOUT_LAST) begin
                        oe_n      <= '1;
                        bus_valid <= 1'b0;
                        grant     <= '0;
                        timeout   <= 1'b1;
                        rr_ptr    <= rr_next;
                        cnt       <= '0;
                        state     <= S_RELEASE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                S_RELEASE: begin
                    if (cnt == TURN_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef TTL373_ARB_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ttl373_bus_arbiter.sv
// Directed-vector bench for ttl373_bus_arbiter (default parameters, 4 sources).
module tb_ttl373_bus_arbiter;
    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic       consumer_ready;
    logic [3:0] le;
    logic [3:0] oe_n;
    logic [3:0] grant;
    logic       bus_valid;
    logic [3:0] ack;
    logic       timeout;

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 0;

    ttl373_bus_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .consumer_ready(consumer_ready),
        .le            (le),
        .oe_n          (oe_n),
        .grant         (grant),
        .bus_valid     (bus_valid),
        .ack           (ack),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bit_index(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // Bus-safety invariants, checked every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if ($countones(~oe_n) > 1 || $countones(le) > 1 || (le & ~oe_n) != 4'b0 ||
                $countones(grant) > 1) begin
                miscompares++;
                $display("FAIL invariant t=%0t le=%b oe_n=%b grant=%b", $time, le, oe_n, grant);
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        req = 4'b0;
        consumer_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_le(output int src, output bit ok);
        ok = 0;
        src = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (le != 4'b0) begin
                ok = 1;
                src = bit_index(le);
            end
        end
    endtask

    task automatic wait_ack(output logic [3:0] a, output bit ok);
        ok = 0;
        a = 4'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (ack != 4'b0) begin
                ok = 1;
                a = ack;
            end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus_valid) ok = 1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({le, oe_n, grant, bus_valid, ack, timeout} !== {4'b0, 4'b1111, 4'b0, 1'b0, 4'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values le=%b oe_n=%b grant=%b bv=%b ack=%b to=%b",
                     le, oe_n, grant, bus_valid, ack, timeout);
        end
    endtask

    task automatic test_single();
        logic [3:0] a;
        bit ok;
        do_reset();
        req = 4'b0001;
        consumer_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({le, grant, oe_n} !== {4'b0001, 4'b0001, 4'b1111}) begin
            miscompares++;
            $display("FAIL single_grant le=%b grant=%b oe_n=%b want 0001/0001/1111", le, grant, oe_n);
        end
        @(negedge clk);
        vectors++;
        if (le !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_le_2nd le=%b want 0001", le);
        end
        @(negedge clk);
        vectors++;
        if ({le, oe_n, bus_valid} !== {4'b0000, 4'b1110, 1'b0}) begin
            miscompares++;
            $display("FAIL single_drive le=%b oe_n=%b bv=%b want 0000/1110/0", le, oe_n, bus_valid);
        end
        @(negedge clk);
        vectors++;
        if ({oe_n, bus_valid} !== {4'b1110, 1'b0}) begin
            miscompares++;
            $display("FAIL single_settle oe_n=%b bv=%b want 1110/0", oe_n, bus_valid);
        end
        @(negedge clk);
        vectors++;
        if ({oe_n, bus_valid} !== {4'b1110, 1'b1}) begin
            miscompares++;
            $display("FAIL single_valid oe_n=%b bv=%b want 1110/1", oe_n, bus_valid);
        end
        @(negedge clk);
        vectors++;
        if ({ack, oe_n, bus_valid, grant} !== {4'b0001, 4'b1111, 1'b0, 4'b0}) begin
            miscompares++;
            $display("FAIL single_ack ack=%b oe_n=%b bv=%b grant=%b want 0001/1111/0/0",
                     ack, oe_n, bus_valid, grant);
        end
        @(negedge clk);
        vectors++;
        if ({ack, le} !== {4'b0, 4'b0}) begin
            miscompares++;
            $display("FAIL single_turnaround ack=%b le=%b want 0000/0000", ack, le);
        end
        @(negedge clk);
        vectors++;
        if (le !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_regrant le=%b want 0001", le);
        end
        req = 4'b0;
        wait_ack(a, ok);
        vectors++;
        if (!ok || a !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_second_ack got=%b ok=%0d want 0001", a, ok);
        end
    endtask

    task automatic test_round_robin();
        int src;
        bit ok;
        logic [3:0] a;
        do_reset();
        req = 4'b1111;
        consumer_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_le(src, ok);
            vectors++;
            if (!ok || src != (k % 4)) begin
                miscompares++;
                $display("FAIL rr_order step=%0d got=%0d want=%0d", k, src, k % 4);
            end
            wait_ack(a, ok);
            if (!ok) begin
                vectors++;
                miscompares++;
                $display("FAIL rr_ack_timeout step=%0d got=none want ack", k);
            end
        end
    endtask

    task automatic test_wrap();
        int src;
        bit ok;
        logic [3:0] a;
        do_reset();
        consumer_ready = 1'b1;
        req = 4'b0001;
        wait_ack(a, ok);
        req = 4'b0010;
        wait_ack(a, ok);
        req = 4'b0011;
        wait_le(src, ok);
        vectors++;
        if (!ok || src != 0) begin
            miscompares++;
            $display("FAIL wrap_grant got=%0d want=0", src);
        end
        wait_ack(a, ok);
        req = 4'b0110;
        wait_le(src, ok);
        vectors++;
        if (!ok || src != 1) begin
            miscompares++;
            $display("FAIL rr_after_wrap got=%0d want=1", src);
        end
        req = 4'b0;
        wait_ack(a, ok);
    endtask

    task automatic test_withdraw();
        int src;
        bit ok;
        logic [3:0] a;
        do_reset();
        consumer_ready = 1'b1;
        req = 4'b0100;
        wait_le(src, ok);
        req = 4'b0;
        vectors++;
        if (!ok || src != 2) begin
            miscompares++;
            $display("FAIL withdraw_grant got=%0d want=2", src);
        end
        wait_ack(a, ok);
        vectors++;
        if (!ok || a !== 4'b0100) begin
            miscompares++;
            $display("FAIL withdraw_ack got=%b want=0100", a);
        end
    endtask

    task automatic test_reset_mid();
        int src;
        bit ok;
        do_reset();
        req = 4'b1000;
        wait_valid(ok);
        vectors++;
        if (!ok || {grant, oe_n} !== {4'b1000, 4'b0111}) begin
            miscompares++;
            $display("FAIL midreset_setup grant=%b oe_n=%b want 1000/0111", grant, oe_n);
        end
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({le, oe_n, grant, bus_valid, ack, timeout} !== {4'b0, 4'b1111, 4'b0, 1'b0, 4'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset le=%b oe_n=%b grant=%b bv=%b ack=%b to=%b",
                     le, oe_n, grant, bus_valid, ack, timeout);
        end
        reset_n = 1'b1;
        req = 4'b1001;
        wait_le(src, ok);
        vectors++;
        if (!ok || src != 0) begin
            miscompares++;
            $display("FAIL midreset_rr got=%0d want=0", src);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        req = 4'b0011;
        wait_valid(ok);
        vectors++;
        if (!ok || grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL to_setup grant=%b want 0001", grant);
        end
`ifdef TTL373_ARB_TIMEOUT_EN
        begin
            int src;
            for (int i = 0; i < 15; i++) @(negedge clk);
            vectors++;
            if ({bus_valid, timeout} !== 2'b10) begin
                miscompares++;
                $display("FAIL to_before bv=%b to=%b want 1/0", bus_valid, timeout);
            end
            @(negedge clk);
            vectors++;
            if ({timeout, bus_valid, ack, oe_n, grant} !== {1'b1, 1'b0, 4'b0, 4'b1111, 4'b0}) begin
                miscompares++;
                $display("FAIL to_abort to=%b bv=%b ack=%b oe_n=%b grant=%b", timeout, bus_valid, ack, oe_n, grant);
            end
            @(negedge clk);
            vectors++;
            if (timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL to_pulse to=%b want 0", timeout);
            end
            wait_le(src, ok);
            vectors++;
            if (!ok || src != 1) begin
                miscompares++;
                $display("FAIL to_next_grant got=%0d want=1", src);
            end
        end
`else
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus_valid, timeout, ack} !== {1'b1, 1'b0, 4'b0}) begin
                miscompares++;
                $display("FAIL no_watchdog cyc=%0d bv=%b to=%b ack=%b want 1/0/0000", i, bus_valid, timeout, ack);
            end
        end
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        req = 4'b0;
        consumer_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mon_en = 1;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_withdraw();
        test_reset_mid();
        test_timeout();
        mon_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
